dma_xfer_monitor: RTL and testbench



---
 rtl/dma_xfer_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_dma_xfer_monitor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_monitor.sv
// Passive protocol monitor for the DMA controller bus side: hold/transfer FSM,
// grant priority, request latency and strobe checks. Optional macro: DMA_MON_EOP_EN.
module dma_xfer_monitor #(
  parameter int NUM_CH   = 4,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic [NUM_CH-1:0]         DACK,
  input  logic                      HRQ,
  input  logic                      HLDA,
  input  logic                      AEN,
  input  logic                      ADSTB,
  input  logic                      IOR_N,
  input  logic                      IOW_N,
  input  logic                      MEMR_N,
  input  logic                      MEMW_N,
  input  logic                      EOP_N,
  input  logic                      priority_rotate,
  input  logic                      clr_err,
  output logic [7:0]                err_vec,
  output logic [ERRCNT_W-1:0]       err_count,
  output logic [2:0]                first_err,
  output logic [NUM_CH*CNT_W-1:0]   svc_count,
  output logic [1:0]                mon_state
);

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_XFER = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [NUM_CH-1:0]   prevDreq, prevDack;
  logic                prevAdstb;
  logic [PTR_W-1:0]    ptr, ptrNext;
  logic [WAIT_W-1:0]   waitCnt [NUM_CH];
  logic [CNT_W-1:0]    svcCnt  [NUM_CH];
  logic [7:0]          errVecQ, detect;
  logic [ERRCNT_W-1:0] errCntQ;
  logic [2:0]          firstErrQ, lowIdx;
  logic [NUM_CH-1:0]   expOneHot, starveHit, dackFall;
  logic                grantStart, eopSeen, eopErr;
  logic [ERRCNT_W+3:0] sumCnt;

`ifdef DMA_MON_EOP_EN
  // EOP seen in XFER obliges DACK to be released on the following cycle.
  logic eopPend;
  assign eopSeen = (state == S_XFER) && !EOP_N;
  assign eopErr  = eopPend && (DACK != '0);
  always_ff @(posedge CLK) begin
    if (RESET) eopPend <= 1'b0;
    else       eopPend <= eopSeen;
  end
`else
  logic unusedEop;
  assign unusedEop = EOP_N;
  assign eopSeen   = 1'b0;
  assign eopErr    = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= stateNext;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE: if (HRQ) stateNext = S_REQ;
      S_REQ: begin
        if (!HRQ)      stateNext = S_IDLE;
        else if (HLDA) stateNext = S_ACK;
      end
      S_ACK: begin
        if (!HRQ)              stateNext = S_IDLE;
        else if (DACK != '0)   stateNext = S_XFER;
      end
      S_XFER: begin
        if (!HLDA)             stateNext = S_IDLE;
        else if (eopSeen)      stateNext = S_IDLE;
        else if (DACK == '0)   stateNext = S_ACK;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mon_state = state;
  end

  // Expected grant: requesting channel with the smallest distance from the search base.
  always_comb begin : grantPick
    int bestRank;
    int rank;
    bestRank  = NUM_CH;
    rank      = 0;
    expOneHot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rank = (c + NUM_CH - (priority_rotate ? int'(ptr) : 0)) % NUM_CH;
      if (prevDreq[c] && (rank < bestRank)) begin
        bestRank     = rank;
        expOneHot    = '0;
        expOneHot[c] = 1'b1;
      end
    end
  end

  assign grantStart = (prevDack == '0) && (DACK != '0);
  assign dackFall   = prevDack & ~DACK;

  always_comb begin
    starveHit = '0;
    for (int c = 0; c < NUM_CH; c++)
      starveHit[c] = DREQ[c] && !DACK[c] && (waitCnt[c] == WAIT_W'(MAX_WAIT - 1));
  end

  always_comb begin
    detect    = '0;
    detect[0] = grantStart && (prevDreq != '0) && (DACK != expOneHot);
    detect[1] = (DACK & (DACK - NUM_CH'(1))) != '0;
    detect[2] = |(DACK & ~prevDack & ~prevDreq);
    detect[3] = (!IOR_N && !IOW_N) || (!MEMR_N && !MEMW_N);
    detect[4] = ADSTB && (prevAdstb || !AEN);
    detect[5] = ((DACK != '0) && !HLDA) || ((state == S_REQ) && !HRQ);
    detect[6] = |starveHit;
    detect[7] = eopErr;
  end

  // When several channels release together the highest index sets the pointer.
  always_comb begin
    ptrNext = ptr;
    for (int c = 0; c < NUM_CH; c++)
      if (dackFall[c]) ptrNext = PTR_W'((c + 1) % NUM_CH);
    if (eopSeen)
      for (int c = 0; c < NUM_CH; c++)
        if (DACK[c]) ptrNext = PTR_W'((c + 1) % NUM_CH);
  end

  always_comb begin
    lowIdx = '0;
    for (int b = 7; b >= 0; b--)
      if (detect[b]) lowIdx = 3'(b);
  end

  assign sumCnt = {4'b0, errCntQ} + (ERRCNT_W + 4)'($countones(detect));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prevDreq  <= '0;
      prevDack  <= '0;
      prevAdstb <= 1'b0;
      ptr       <= '0;
      errVecQ   <= '0;
      errCntQ   <= '0;
      firstErrQ <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        waitCnt[c] <= '0;
        svcCnt[c]  <= '0;
      end
    end else begin
      prevDreq  <= DREQ;
      prevDack  <= DACK;
      prevAdstb <= ADSTB;
      ptr       <= ptrNext;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!DREQ[c] || DACK[c])                    waitCnt[c] <= '0;
        else if (waitCnt[c] != WAIT_W'(MAX_WAIT))   waitCnt[c] <= waitCnt[c] + 1'b1;
        if (dackFall[c]) svcCnt[c] <= svcCnt[c] + 1'b1;
      end
      if (clr_err) begin
        errVecQ   <= '0;
        errCntQ   <= '0;
        firstErrQ <= '0;
      end else begin
        errVecQ <= errVecQ | detect;
        errCntQ <= (sumCnt > {4'b0, ERR_MAX}) ? ERR_MAX : sumCnt[ERRCNT_W-1:0];
        if ((errVecQ == '0) && (detect != '0)) firstErrQ <= lowIdx;
      end
    end
  end

  assign err_vec   = errVecQ;
  assign err_count = errCntQ;
  assign first_err = firstErrQ;

  always_comb begin
    svc_count = '0;
    for (int c = 0; c < NUM_CH; c++)
      svc_count[c*CNT_W +: CNT_W] = svcCnt[c];
  end

endmodule

// File: tb/tb_dma_xfer_monitor.sv
// Bench for dma_xfer_monitor: reset/table vectors, directed corner sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_dma_xfer_monitor;

  localparam int NUM_CH   = 4;
  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 16;
  localparam int ERRCNT_W = 8;

  logic CLK = 1'b0;
  logic RESET;
  logic [3:0] DREQ, DACK;
  logic HRQ, HLDA, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N;
  logic priority_rotate, clr_err;
  logic [7:0]  err_vec;
  logic [7:0]  err_count;
  logic [2:0]  first_err;
  logic [63:0] svc_count;
  logic [1:0]  mon_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  dma_xfer_monitor #(
    .NUM_CH(NUM_CH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .HRQ(HRQ), .HLDA(HLDA),
    .AEN(AEN), .ADSTB(ADSTB), .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N),
    .MEMW_N(MEMW_N), .EOP_N(EOP_N), .priority_rotate(priority_rotate),
    .clr_err(clr_err), .err_vec(err_vec), .err_count(err_count),
    .first_err(first_err), .svc_count(svc_count), .mon_state(mon_state)
  );

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] dack;
    logic       hrq;
    logic       hlda;
    logic       clr;
    logic [1:0] exp_state;
    logic [7:0] exp_err;
    logic [7:0] exp_cnt;
    logic [2:0] exp_first;
  } vec_t;

  vec_t vecs [8];

  // ---------------- reference model state ----------------
  logic [3:0] m_prev_dreq, m_prev_dack;
  logic       m_prev_adstb;
  int         m_ptr;
  int         m_wait [NUM_CH];
  int         m_svc  [NUM_CH];
  logic [7:0] m_err;
  int         m_cnt;
  logic [2:0] m_first;

  logic [18:0] exp_q [$];

  function automatic logic bit_of(input logic [3:0] v, input int i);
    logic [3:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [15:0] svc_of(input int c);
    logic [63:0] t;
    t = svc_count >> (c * CNT_W);
    return t[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    DREQ = 4'b0; DACK = 4'b0; HRQ = 1'b0; HLDA = 1'b0; AEN = 1'b0; ADSTB = 1'b0;
    IOR_N = 1'b1; IOW_N = 1'b1; MEMR_N = 1'b1; MEMW_N = 1'b1; EOP_N = 1'b1;
    priority_rotate = 1'b0; clr_err = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic model_reset();
    m_prev_dreq = 4'b0; m_prev_dack = 4'b0; m_prev_adstb = 1'b0; m_ptr = 0;
    m_err = 8'b0; m_cnt = 0; m_first = 3'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_wait[c] = 0;
      m_svc[c]  = 0;
    end
  endtask

  // Applies the monitor rules to the inputs sampled on this edge.
  task automatic model_step();
    logic [7:0] det;
    int base, winner, n;
    logic found;
    det = 8'b0;
    if (m_prev_dack == 4'b0 && DACK != 4'b0 && m_prev_dreq != 4'b0) begin
      base = priority_rotate ? m_ptr : 0;
      found = 1'b0;
      winner = 0;
      for (int k = 0; k < NUM_CH; k++)
        if (!found && bit_of(m_prev_dreq, (base + k) % NUM_CH)) begin
          found = 1'b1;
          winner = (base + k) % NUM_CH;
        end
      if (DACK != 4'(1 << winner)) det[0] = 1'b1;
    end
    if ($countones(DACK) > 1) det[1] = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (bit_of(DACK, c) && !bit_of(m_prev_dack, c) && !bit_of(m_prev_dreq, c)) det[2] = 1'b1;
    if ((!IOR_N && !IOW_N) || (!MEMR_N && !MEMW_N)) det[3] = 1'b1;
    if (ADSTB && (m_prev_adstb || !AEN)) det[4] = 1'b1;
    if (DACK != 4'b0 && !HLDA) det[5] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bit_of(DREQ, c) && !bit_of(DACK, c)) begin
        if (m_wait[c] == MAX_WAIT - 1) det[6] = 1'b1;
        if (m_wait[c] < MAX_WAIT) m_wait[c]++;
      end else begin
        m_wait[c] = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (bit_of(m_prev_dack, c) && !bit_of(DACK, c)) begin
        m_svc[c] = (m_svc[c] + 1) % (1 << CNT_W);
        m_ptr = (c + 1) % NUM_CH;
      end
    if (clr_err) begin
      m_err = 8'b0; m_cnt = 0; m_first = 3'b0;
    end else begin
      if (m_err == 8'b0 && det != 8'b0) begin
        found = 1'b0;
        for (int b = 0; b < 8; b++)
          if (!found && det[b]) begin
            found = 1'b1;
            m_first = 3'(b);
          end
      end
      m_err = m_err | det;
      n = m_cnt + $countones(det);
      m_cnt = (n > (1 << ERRCNT_W) - 1) ? (1 << ERRCNT_W) - 1 : n;
    end
    m_prev_dreq = DREQ; m_prev_dack = DACK; m_prev_adstb = ADSTB;
  endtask

  task automatic step_model();
    logic [18:0] e;
    @(posedge CLK);
    model_step();
    exp_q.push_back({m_err, 8'(m_cnt), m_first});
    #1;
    e = exp_q.pop_front();
    check("rand_err_cnt_first", 32'({err_vec, err_count, first_err}), 32'(e));
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("rand_svc%0d", c), 32'(svc_of(c)), 32'(m_svc[c][15:0]));
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    step();
    step();
    check("reset_err_vec", 32'(err_vec), 32'h0);
    check("reset_err_count", 32'(err_count), 32'h0);
    check("reset_first_err", 32'(first_err), 32'h0);
    check("reset_svc", 32'(svc_count), 32'h0);
    check("reset_state", 32'(mon_state), 32'h0);
    RESET = 1'b0;

    // ---- table: fixed-priority grant, legal then wrong channel ----
    vecs[0] = '{4'b0110, 4'b0000, 1, 0, 0, 2'd1, 8'h00, 8'd0, 3'd0};
    vecs[1] = '{4'b0110, 4'b0000, 1, 1, 0, 2'd2, 8'h00, 8'd0, 3'd0};
    vecs[2] = '{4'b0110, 4'b0010, 1, 1, 0, 2'd3, 8'h00, 8'd0, 3'd0};
    vecs[3] = '{4'b0110, 4'b0000, 1, 1, 0, 2'd2, 8'h00, 8'd0, 3'd0};
    vecs[4] = '{4'b0110, 4'b0100, 1, 1, 0, 2'd3, 8'h01, 8'd1, 3'd0};
    vecs[5] = '{4'b0110, 4'b0000, 1, 1, 0, 2'd2, 8'h01, 8'd1, 3'd0};
    vecs[6] = '{4'b0110, 4'b0000, 1, 1, 1, 2'd2, 8'h00, 8'd0, 3'd0};
    vecs[7] = '{4'b0000, 4'b0000, 1, 1, 0, 2'd2, 8'h00, 8'd0, 3'd0};
    for (int i = 0; i < 8; i++) begin
      DREQ = vecs[i].dreq; DACK = vecs[i].dack; HRQ = vecs[i].hrq;
      HLDA = vecs[i].hlda; clr_err = vecs[i].clr;
      step();
      check($sformatf("vec%0d_state", i), 32'(mon_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_err_vec", i), 32'(err_vec), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_first_err", i), 32'(first_err), 32'(vecs[i].exp_first));
      if (i == 3) check("svc1_after_fall", 32'(svc_of(1)), 32'd1);
    end
    clr_err = 1'b0;
    check("svc2_after_fall", 32'(svc_of(2)), 32'd1);

    // ---- rotating priority: ptr=2 wraps to ch0 ----
    priority_rotate = 1'b1;
    DREQ = 4'b0010; step();
    DACK = 4'b0010; step();
    DACK = 4'b0000; step();
    DREQ = 4'b0011; step();
    DACK = 4'b0001; step();
    check("rot_legal_ch0", 32'(err_vec), 32'h00);
    DACK = 4'b0000; DREQ = 4'b0010; step();
    DACK = 4'b0010; step();
    check("rot_legal_ch1", 32'(err_vec), 32'h00);
    DACK = 4'b0000; step();
    DREQ = 4'b0011; step();
    DACK = 4'b0010; step();
    check("rot_prio_err", 32'(err_vec), 32'h01);
    check("rot_prio_count", 32'(err_count), 32'd1);
    DACK = 4'b0000; DREQ = 4'b0000; priority_rotate = 1'b0;
    clear_errors();

    // ---- starvation of ch3 ----
    DREQ = 4'b1000;
    repeat (MAX_WAIT - 1) step();
    check("starve_early", 32'(err_vec), 32'h00);
    step();
    check("starve_set", 32'(err_vec), 32'h40);
    check("starve_count", 32'(err_count), 32'd1);
    check("starve_first", 32'(first_err), 32'd6);
    repeat (5) step();
    check("starve_once", 32'(err_count), 32'd1);
    clear_errors();
    check("clr_err_vec", 32'(err_vec), 32'h00);
    check("clr_err_count", 32'(err_count), 32'd0);
    check("clr_first_err", 32'(first_err), 32'd0);
    DREQ = 4'b0000;

    // ---- read/write overlap plus back-to-back ADSTB ----
    AEN = 1'b1;
    IOR_N = 1'b0; IOW_N = 1'b0; ADSTB = 1'b1; step();
    IOR_N = 1'b1; IOW_N = 1'b1; step();
    ADSTB = 1'b0; step();
    check("rw_stb_err_vec", 32'(err_vec), 32'h18);
    check("rw_stb_count", 32'(err_count), 32'd2);
    check("rw_stb_first", 32'(first_err), 32'd3);
    AEN = 1'b0;
    clear_errors();

    // ---- reset mid-transfer, then EOP handling ----
    DREQ = 4'b0001; step();
    DACK = 4'b0001; step();
    check("xfer_before_reset", 32'(mon_state), 32'd3);
    RESET = 1'b1; step();
    check("midreset_state", 32'(mon_state), 32'd0);
    check("midreset_svc", 32'(svc_count), 32'h0);
    check("midreset_err", 32'({err_vec, err_count}), 32'h0);
    RESET = 1'b0; DACK = 4'b0000; HRQ = 1'b1; HLDA = 1'b0; step();
    check("eop_req", 32'(mon_state), 32'd1);
    HLDA = 1'b1; step();
    DACK = 4'b0001; step();
    check("eop_xfer", 32'(mon_state), 32'd3);
    EOP_N = 1'b0; step();
`ifdef DMA_MON_EOP_EN
    check("eop_state_idle", 32'(mon_state), 32'd0);
`else
    check("eop_ignored_state", 32'(mon_state), 32'd3);
`endif
    EOP_N = 1'b1; step();
`ifdef DMA_MON_EOP_EN
    check("eop_err_vec", 32'(err_vec), 32'h80);
`else
    check("eop_err_vec", 32'(err_vec), 32'h00);
`endif
    DACK = 4'b0000; step();

    // ---- randomized traffic against the reference model ----
    idle_inputs();
    RESET = 1'b1; step();
    RESET = 1'b0;
    model_reset();
    HRQ = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int phase, r;
      phase = cyc / 500;
      priority_rotate = phase[0];
      DREQ = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 60)      DACK = 4'b0;
      else if (r < 95) DACK = 4'(1 << $urandom_range(0, 3));
      else             DACK = 4'($urandom_range(1, 15));
      if (phase == 2) begin
        DREQ[3] = 1'b1;
        DACK[3] = 1'b0;
      end
      HLDA   = ($urandom_range(0, 19) != 0);
      IOR_N  = ($urandom_range(0, 9) != 0);
      IOW_N  = ($urandom_range(0, 9) != 0);
      MEMR_N = ($urandom_range(0, 9) != 0);
      MEMW_N = ($urandom_range(0, 9) != 0);
      AEN    = ($urandom_range(0, 9) != 0);
      ADSTB  = ($urandom_range(0, 3) == 0);
      clr_err = ($urandom_range(0, 39) == 0);
      step_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
